l1_dcache_mesi: RTL and testbench

- Per-core L1 data cache controller sitting directly downstream of the core's load/store port; one instance per core.
- Direct-mapped, one 32-bit word per line, write-back/write-allocate, MESI coherent over a shared snooping bus.
- Consumes load_control/store_control/address/dmem_wdata; returns dmem_rdata; drives L1_busy to freeze the core's PC and instruction register on misses.

---
 rtl/l1_dcache_mesi.sv | 178 +++++++++++++++++
 tb/tb_l1_dcache_mesi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_mesi.sv
// Direct-mapped, write-back/write-allocate L1 data cache with MESI coherence over a snooping bus.
// One 32-bit word per line; the core holds its request until L1_busy falls.
module l1_dcache_mesi #(
    parameter int n        = 32,
    parameter int idx_bits = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_control,
    input  logic         store_control,
    input  logic [14:0]  address,
    input  logic [n-1:0] dmem_wdata,
    output logic [n-1:0] dmem_rdata,
    output logic         L1_busy,
    output logic         bus_req,
    input  logic         bus_gnt,
    output logic [1:0]   bus_cmd,
    output logic [14:0]  bus_addr,
    output logic [n-1:0] bus_wdata,
    input  logic [n-1:0] bus_rdata,
    input  logic         bus_done,
    input  logic         bus_shared,
    input  logic         snoop_valid,
    input  logic [1:0]   snoop_cmd,
    input  logic [14:0]  snoop_addr,
    output logic         snoop_hit,
    output logic         snoop_flush,
    output logic [n-1:0] snoop_data
);
    localparam int TAG_W = 15 - idx_bits;
    localparam int LINES = 1 << idx_bits;

    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] CMD_WB = 2'b00, CMD_RD = 2'b01, CMD_RDX = 2'b10, CMD_UPG = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPG_REQ, UPG_WAIT, RESP
    } fsm_t;

    fsm_t state_q, state_d;

    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [n-1:0]     data_arr [LINES];
    logic [1:0]       st_arr   [LINES];

    logic [idx_bits-1:0] idx, sidx;
    logic [TAG_W-1:0]    tag, stag;
    logic [1:0]          line_st, snoop_st, snoop_next_st;
    logic                req, hit, hit_done, snoop_act, conflict, snoop_kill;
    logic                wr_core, wr_upg, wr_fill, wr_evict;

    assign idx      = address[idx_bits-1:0];
    assign tag      = address[14:idx_bits];
    assign sidx     = snoop_addr[idx_bits-1:0];
    assign stag     = snoop_addr[14:idx_bits];
    assign line_st  = st_arr[idx];
    assign snoop_st = st_arr[sidx];
    assign req      = load_control | store_control;
    assign hit      = (line_st != ST_I) && (tag_arr[idx] == tag);

    assign snoop_hit   = snoop_valid && (snoop_st != ST_I) && (tag_arr[sidx] == stag);
    assign snoop_flush = snoop_hit && (snoop_st == ST_M) && (snoop_cmd == CMD_RD || snoop_cmd == CMD_RDX);
    assign snoop_data  = snoop_flush ? data_arr[sidx] : '0;
    assign snoop_act   = snoop_hit && (snoop_cmd != CMD_WB);

    // A snoop on the line the core is touching takes the cycle; the core retries next cycle.
    assign conflict   = snoop_act && (sidx == idx);
    assign snoop_kill = conflict && (snoop_cmd == CMD_RDX || snoop_cmd == CMD_UPG);

    assign hit_done = (state_q == IDLE) && req && hit && !conflict &&
                      (!store_control || line_st == ST_M || line_st == ST_E);

    assign wr_core  = hit_done && store_control;
    assign wr_upg   = (state_q == UPG_WAIT) && bus_done;
    assign wr_fill  = (state_q == FILL_WAIT) && bus_done;
    assign wr_evict = (state_q == WB_WAIT) && bus_done;

    always_comb begin
        snoop_next_st = snoop_st;
        case (snoop_cmd)
            CMD_RD:  if (snoop_st == ST_M || snoop_st == ST_E) snoop_next_st = ST_S;
            CMD_RDX: snoop_next_st = ST_I;
            CMD_UPG: if (snoop_st == ST_S) snoop_next_st = ST_I;
            default: snoop_next_st = snoop_st;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !conflict) begin
                    if (hit) begin
                        if (store_control && line_st == ST_S) state_d = UPG_REQ;
                    end else if (line_st == ST_M) begin
                        state_d = WB_REQ;
                    end else begin
                        state_d = FILL_REQ;
                    end
                end
            end
            // A victim already downgraded by a snoop has been supplied to the bus; skip its writeback.
            WB_REQ:    if (line_st != ST_M || conflict) state_d = FILL_REQ;
                       else if (bus_gnt) state_d = WB_WAIT;
            WB_WAIT:   if (bus_done) state_d = FILL_REQ;
            FILL_REQ:  if (bus_gnt) state_d = FILL_WAIT;
            FILL_WAIT: if (bus_done) state_d = RESP;
            UPG_REQ:   if (!hit || snoop_kill) state_d = FILL_REQ;
                       else if (bus_gnt) state_d = UPG_WAIT;
            UPG_WAIT:  if (bus_done) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req    = 1'b0;
        bus_cmd    = CMD_WB;
        bus_addr   = '0;
        bus_wdata  = '0;
        dmem_rdata = '0;
        L1_busy    = reset && req && !hit_done && (state_q != RESP);
        case (state_q)
            WB_REQ, WB_WAIT: begin
                bus_req   = (state_q == WB_REQ);
                bus_cmd   = CMD_WB;
                bus_addr  = {tag_arr[idx], idx};
                bus_wdata = data_arr[idx];
            end
            FILL_REQ, FILL_WAIT: begin
                bus_req  = (state_q == FILL_REQ);
                bus_cmd  = store_control ? CMD_RDX : CMD_RD;
                bus_addr = address;
            end
            UPG_REQ, UPG_WAIT: begin
                bus_req  = (state_q == UPG_REQ);
                bus_cmd  = CMD_UPG;
                bus_addr = address;
            end
            default: ;
        endcase
        if ((state_q == RESP) || (hit_done && load_control)) dmem_rdata = data_arr[idx];
    end

    // Snoop update is applied last so it overrides any core-side update to the same line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) st_arr[i] <= ST_I;
        end else begin
            if (wr_core || wr_upg) begin
                st_arr[idx] <= ST_M;
            end else if (wr_fill) begin
                st_arr[idx] <= store_control ? ST_M : (bus_shared ? ST_S : ST_E);
            end else if (wr_evict) begin
                st_arr[idx] <= ST_I;
            end
            if (snoop_act) st_arr[sidx] <= snoop_next_st;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_core || wr_upg) begin
            data_arr[idx] <= dmem_wdata;
        end else if (wr_fill) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= store_control ? dmem_wdata : bus_rdata;
        end
    end

endmodule

// File: tb/tb_l1_dcache_mesi.sv
// Scoreboard bench for l1_dcache_mesi: expected bus transactions and load data are queued
// when a core access is issued and checked as the cache issues requests and completes.
module tb_l1_dcache_mesi;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_control = 1'b0, store_control = 1'b0;
    logic [14:0] address = '0;
    logic [31:0] dmem_wdata = '0, dmem_rdata;
    logic        L1_busy, bus_req, bus_gnt = 1'b0;
    logic [1:0]  bus_cmd;
    logic [14:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata = '0;
    logic        bus_done = 1'b0, bus_shared = 1'b0;
    logic        snoop_valid = 1'b0;
    logic [1:0]  snoop_cmd = '0;
    logic [14:0] snoop_addr = '0;
    logic        snoop_hit, snoop_flush;
    logic [31:0] snoop_data;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [14:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    bus_txn_t    exp_bus[$];
    logic [31:0] exp_rd[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_dcache_mesi #(.n(32), .idx_bits(6)) dut (
        .clk(clk), .reset(reset),
        .load_control(load_control), .store_control(store_control),
        .address(address), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .L1_busy(L1_busy), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_done(bus_done), .bus_shared(bus_shared),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_hit(snoop_hit), .snoop_flush(snoop_flush), .snoop_data(snoop_data)
    );

    task automatic push_bus(input logic [1:0] cmd, input logic [14:0] a, input logic [31:0] wd);
        bus_txn_t t;
        t.cmd = cmd; t.addr = a; t.wdata = wd;
        exp_bus.push_back(t);
    endtask

    // Acts as arbiter/memory for an already-driven core request; call at a negedge.
    task automatic serve(input logic [31:0] fill, input logic sh, input int exp_lat, input string nm);
        int ph;
        bit fin;
        bus_txn_t e;
        logic [31:0] er;
        ph = 0;
        fin = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            #1;
            if (ph == 1) begin
                bus_gnt = 1'b0; bus_done = 1'b1; bus_rdata = fill; bus_shared = sh; ph = 2;
                checks++;
                if (bus_req !== 1'b0) begin
                    errors++; $display("FAIL %s req_in_wait: got %b want 0", nm, bus_req);
                end
            end else if (ph == 2) begin
                bus_done = 1'b0; ph = 0;
            end
            if (L1_busy === 1'b0) begin
                fin = 1;
                if (exp_lat >= 0) begin
                    checks++;
                    if (c != exp_lat) begin
                        errors++; $display("FAIL %s latency: got %0d want %0d", nm, c, exp_lat);
                    end
                end
                if (load_control && exp_rd.size() > 0) begin
                    er = exp_rd.pop_front();
                    checks++;
                    if (dmem_rdata !== er) begin
                        errors++; $display("FAIL %s rdata: got %h want %h", nm, dmem_rdata, er);
                    end
                end
            end else if (ph == 0 && bus_req === 1'b1) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    errors++; $display("FAIL %s unexpected_req: cmd %b addr %h", nm, bus_cmd, bus_addr);
                end else begin
                    e = exp_bus.pop_front();
                    if (bus_cmd !== e.cmd || bus_addr !== e.addr ||
                        (e.cmd == 2'b00 && bus_wdata !== e.wdata)) begin
                        errors++;
                        $display("FAIL %s bus_txn: got %b/%h/%h want %b/%h/%h", nm,
                                 bus_cmd, bus_addr, bus_wdata, e.cmd, e.addr, e.wdata);
                    end
                end
                bus_gnt = 1'b1; ph = 1;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            errors++; $display("FAIL %s timeout: L1_busy stuck at %b", nm, L1_busy);
        end
        checks++;
        if (exp_bus.size() != 0) begin
            errors++; $display("FAIL %s missing_txn: %0d left want 0", nm, exp_bus.size());
        end
        exp_bus.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        load_control = 1'b0; store_control = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic core_access(input bit st, input logic [14:0] a, input logic [31:0] wd,
                               input logic [31:0] fill, input logic sh, input int lat,
                               input logic [31:0] er, input string nm);
        address = a; dmem_wdata = wd;
        load_control = !st; store_control = st;
        if (!st) exp_rd.push_back(er);
        serve(fill, sh, lat, nm);
    endtask

    task automatic do_snoop(input logic [1:0] cmd, input logic [14:0] a, input logic eh,
                            input logic ef, input logic [31:0] ed, input string nm);
        snoop_valid = 1'b1; snoop_cmd = cmd; snoop_addr = a;
        #1;
        checks++;
        if (snoop_hit !== eh) begin errors++; $display("FAIL %s snoop_hit: got %b want %b", nm, snoop_hit, eh); end
        checks++;
        if (snoop_flush !== ef) begin errors++; $display("FAIL %s snoop_flush: got %b want %b", nm, snoop_flush, ef); end
        checks++;
        if (snoop_data !== ed) begin errors++; $display("FAIL %s snoop_data: got %h want %h", nm, snoop_data, ed); end
        @(negedge clk);
        snoop_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, L1_busy, bus_cmd} !== 4'b0 || dmem_rdata !== 32'h0 ||
            bus_addr !== 15'h0 || bus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req %b busy %b cmd %b addr %h wd %h rd %h want all 0",
                     bus_req, L1_busy, bus_cmd, bus_addr, bus_wdata, dmem_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_and_hits;
        push_bus(2'b01, 15'h0040, 32'h0);
        core_access(0, 15'h0040, 32'h0, 32'hDEADBEEF, 1'b0, -1, 32'hDEADBEEF, "load_miss");
        core_access(0, 15'h0040, 32'h0, 32'h0, 1'b0, 0, 32'hDEADBEEF, "load_hit1");
        core_access(0, 15'h0040, 32'h0, 32'h0, 1'b0, 0, 32'hDEADBEEF, "load_hit2");
    endtask

    task automatic test_store_and_snoop;
        core_access(1, 15'h0040, 32'h12345678, 32'h0, 1'b0, 0, 32'h0, "store_e");
        do_snoop(2'b01, 15'h0040, 1'b1, 1'b1, 32'h12345678, "snoop_rd_m");
        core_access(0, 15'h0040, 32'h0, 32'h0, 1'b0, 0, 32'h12345678, "load_after_flush");
    endtask

    task automatic test_upgrade;
        push_bus(2'b01, 15'h0041, 32'h0);
        core_access(0, 15'h0041, 32'h0, 32'h600D0041, 1'b1, -1, 32'h600D0041, "load_shared");
        push_bus(2'b11, 15'h0041, 32'h0);
        core_access(1, 15'h0041, 32'hA5A5A5A5, 32'h0, 1'b0, -1, 32'h0, "store_upg");
        do_snoop(2'b10, 15'h0041, 1'b1, 1'b1, 32'hA5A5A5A5, "snoop_rdx_m");
        do_snoop(2'b10, 15'h0041, 1'b0, 1'b0, 32'h0, "snoop_after_inv");
    endtask

    task automatic test_eviction;
        push_bus(2'b11, 15'h0040, 32'h0);
        core_access(1, 15'h0040, 32'hCAFEF00D, 32'h0, 1'b0, -1, 32'h0, "store_upg_40");
        push_bus(2'b00, 15'h0040, 32'hCAFEF00D);
        push_bus(2'b01, 15'h0080, 32'h0);
        core_access(0, 15'h0080, 32'h0, 32'h0BADF00D, 1'b1, -1, 32'h0BADF00D, "evict_fill");
        do_snoop(2'b01, 15'h0080, 1'b1, 1'b0, 32'h0, "snoop_rd_s");
    endtask

    task automatic test_upgrade_race;
        address = 15'h0080; dmem_wdata = 32'h11223344; store_control = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_cmd !== 2'b11) begin
            errors++; $display("FAIL race_upg_req: got req %b cmd %b want 1/11", bus_req, bus_cmd);
        end
        snoop_valid = 1'b1; snoop_cmd = 2'b11; snoop_addr = 15'h0080;
        #1;
        checks++;
        if (snoop_hit !== 1'b1) begin errors++; $display("FAIL race_snoop_hit: got %b want 1", snoop_hit); end
        @(negedge clk);
        snoop_valid = 1'b0;
        push_bus(2'b10, 15'h0080, 32'h0);
        serve(32'hFFFFFFFF, 1'b0, -1, "race_rdx");
        do_snoop(2'b01, 15'h0080, 1'b1, 1'b1, 32'h11223344, "race_final_m");
    endtask

    task automatic test_reset_mid_fill;
        address = 15'h0102; load_control = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_cmd !== 2'b01) begin
            errors++; $display("FAIL rst_fill_req: got req %b cmd %b want 1/01", bus_req, bus_cmd);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        #1;
        bus_gnt = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || L1_busy !== 1'b1) begin
            errors++; $display("FAIL rst_fill_wait: got req %b busy %b want 0/1", bus_req, L1_busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || L1_busy !== 1'b0 || dmem_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_fill: got req %b busy %b rd %h want 0/0/0", bus_req, L1_busy, dmem_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        push_bus(2'b01, 15'h0102, 32'h0);
        exp_rd.push_back(32'h0000CAFE);
        serve(32'h0000CAFE, 1'b0, -1, "rst_refill");
    endtask

    task automatic test_snoop_conflict;
        address = 15'h0102; load_control = 1'b1;
        snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_addr = 15'h0102;
        #1;
        checks++;
        if (L1_busy !== 1'b1 || snoop_hit !== 1'b1) begin
            errors++; $display("FAIL conflict_stall: got busy %b hit %b want 1/1", L1_busy, snoop_hit);
        end
        @(negedge clk);
        snoop_valid = 1'b0;
        push_bus(2'b01, 15'h0102, 32'h0);
        exp_rd.push_back(32'h3C3C3C3C);
        serve(32'h3C3C3C3C, 1'b0, -1, "conflict_retry");
    endtask

    initial begin
        test_reset();
        test_fill_and_hits();
        test_store_and_snoop();
        test_upgrade();
        test_eviction();
        test_upgrade_race();
        test_reset_mid_fill();
        test_snoop_conflict();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
